ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 16, SHALL set the maximum number of host wait cycles before timeout (legal range 2..255).
REQ-002 CLK  in  1  SHALL be the rising-edge clock for all state.
REQ-003 RSTb  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 ENG_CSb  in  1  SHALL be the engine chip select, active-low.
REQ-005 ENG_WEb  in  1  SHALL be the engine write enable, active-low.
REQ-006 ENG_ADDR  in  8  SHALL be the engine word address.
REQ-007 ENG_WDATA  in  32  SHALL be the engine write data.
REQ-008 ENG_RDATA  out  32  SHALL be the engine read data, a combinational copy of RAM_DOUT.
REQ-009 HOST_REQ  in  1  SHALL be the host request, a level signal.
REQ-010 HOST_WE  in  1  SHALL be the host write flag (1 = write).
REQ-011 HOST_ADDR  in  8  SHALL be the host word address.
REQ-012 HOST_WDATA  in  32  SHALL be the host write data.
REQ-013 HOST_ACK  out  1  SHALL be a one-cycle host completion pulse.
REQ-014 HOST_ERR  out  1  SHALL be a timeout flag, valid only with HOST_ACK.
REQ-015 HOST_RDATA  out  32  SHALL be the registered host read data.
REQ-016 CNT_CLR  in  1  SHALL synchronously clear STALL_CNT.
REQ-017 STALL_CNT  out  16  SHALL be a saturating count of host cycles blocked by the engine.
REQ-018 RAM_CSb, RAM_WEb, RAM_ADDR[7:0], RAM_DIN[31:0]  out  SHALL drive the single-port synchronous RAM; RAM_DOUT[31:0]  in  SHALL carry RAM read data, valid in the cycle after the access cycle.

Function
REQ-019 The engine SHALL have absolute priority: whenever ENG_CSb=0, the RAM_* outputs SHALL equal the ENG_* inputs in the same cycle, and the engine SHALL never be stalled.
REQ-020 The host FSM SHALL have four states: IDLE, WAIT, CAPT and ACK.
REQ-021 IDLE: on HOST_REQ=1, HOST_WE/ADDR/WDATA SHALL be latched into internal registers, the wait counter SHALL be cleared, and the FSM SHALL go to WAIT; requests SHALL be accepted only in IDLE.
REQ-022 WAIT with ENG_CSb=1: RAM_CSb=0, RAM_WEb=~latched WE, and RAM_ADDR/RAM_DIN SHALL be driven from the latched registers this cycle; next state SHALL be CAPT.
REQ-023 WAIT with ENG_CSb=0: the host SHALL get no access, the wait counter SHALL increment, and STALL_CNT SHALL increment (saturating at 16'hFFFF).
REQ-024 Timeout: in WAIT with ENG_CSb=0 and wait counter = MAX_WAIT-1, the FSM SHALL go directly to ACK with HOST_ERR=1, with no RAM access and HOST_RDATA set to 32'h0.
REQ-025 CAPT: for a read, HOST_RDATA SHALL capture RAM_DOUT at the end of the cycle; for a write, HOST_RDATA SHALL be unchanged; next state SHALL be ACK; engine activity in CAPT SHALL NOT corrupt the capture.
REQ-026 ACK: HOST_ACK=1 for exactly one cycle, HOST_ERR SHALL be asserted per REQ-024 and otherwise 0, and the next state SHALL be IDLE.
REQ-027 The requester SHALL drop HOST_REQ during ACK; if HOST_REQ is still high in the following IDLE cycle, that SHALL be treated as a new request.
REQ-028 When neither the engine nor the host accesses the RAM: RAM_CSb=1, RAM_WEb=1, RAM_ADDR=0, RAM_DIN=0.
REQ-029 Latency SHALL be as follows:
- Unblocked read or write: HOST_ACK exactly 3 cycles after the request-accept edge (WAIT, CAPT, ACK).
- Each engine-blocked cycle SHALL add 1 cycle.
REQ-030 CNT_CLR SHALL take priority over a same-cycle STALL_CNT increment; the result SHALL be 0.
REQ-031 Host input changes after acceptance SHALL have no effect until the next IDLE.

Reset
REQ-032 On RSTb=0, asynchronously: FSM=IDLE, latched registers and wait counter = 0, HOST_ACK=0, HOST_ERR=0, HOST_RDATA=32'h0, STALL_CNT=0, RAM_* idle per REQ-028 unless ENG_CSb=0 (engine pass-through remains combinational).
REQ-033 Reset mid-transaction SHALL abandon the transaction: no ACK and no pending RAM access after release.

Verification
REQ-034 Host write addr 8'h05 data 32'hA5A5_0001 with engine idle, then host read addr 8'h05 -> RAM write in WAIT cycle; read ACK 3 cycles after accept; HOST_RDATA=32'hA5A5_0001; HOST_ERR=0.
REQ-035 Engine holds ENG_CSb=0 for 3 cycles from host accept -> host access in 4th WAIT cycle; ACK at cycle 6; STALL_CNT=3; engine signals seen on RAM_* in every blocked cycle.
REQ-036 Engine holds ENG_CSb=0 continuously, MAX_WAIT=16 -> ACK with HOST_ERR=1 after 16 WAIT cycles; HOST_RDATA=0; no RAM cycle with host address.
REQ-037 Engine read of addr 8'h07 in the CAPT cycle of a host read of addr 8'h05 -> HOST_RDATA = contents of 8'h05; ENG_RDATA = contents of 8'h07 on the next cycle.
REQ-038 RSTb asserted in WAIT, released 2 cycles later -> no HOST_ACK; STALL_CNT=0; next HOST_REQ served normally.
REQ-039 CNT_CLR=1 in the same cycle as a blocked WAIT cycle with STALL_CNT=16'hFFFF -> STALL_CNT=0 next cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between a priority engine port and a
// request/acknowledge host port that waits for the engine, with a timeout.
module ram_port_arbiter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        ENG_CSb,
    input  logic        ENG_WEb,
    input  logic [7:0]  ENG_ADDR,
    input  logic [31:0] ENG_WDATA,
    output logic [31:0] ENG_RDATA,
    input  logic        HOST_REQ,
    input  logic        HOST_WE,
    input  logic [7:0]  HOST_ADDR,
    input  logic [31:0] HOST_WDATA,
    output logic        HOST_ACK,
    output logic        HOST_ERR,
    output logic [31:0] HOST_RDATA,
    input  logic        CNT_CLR,
    output logic [15:0] STALL_CNT,
    output logic        RAM_CSb,
    output logic        RAM_WEb,
    output logic [7:0]  RAM_ADDR,
    output logic [31:0] RAM_DIN,
    input  logic [31:0] RAM_DOUT
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        lat_we;
    logic [7:0]  lat_addr;
    logic [31:0] lat_wdata;
    logic [7:0]  wait_cnt;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [15:0] stall_q;

    logic        accept;
    logic        host_access;
    logic        blocked;
    logic        timeout;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        host_access = 1'b0;
        blocked     = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (HOST_REQ) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (ENG_CSb) begin
                    host_access = 1'b1;
                    next_state  = CAPT;
                end else begin
                    blocked = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        timeout    = 1'b1;
                        next_state = ACK;
                    end
                end
            end
            CAPT:    next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The engine always wins the RAM; the host only drives it in an unblocked WAIT cycle.
    always_comb begin
        RAM_CSb  = 1'b1;
        RAM_WEb  = 1'b1;
        RAM_ADDR = 8'h00;
        RAM_DIN  = 32'h0;
        if (!ENG_CSb) begin
            RAM_CSb  = 1'b0;
            RAM_WEb  = ENG_WEb;
            RAM_ADDR = ENG_ADDR;
            RAM_DIN  = ENG_WDATA;
        end else if (host_access) begin
            RAM_CSb  = 1'b0;
            RAM_WEb  = ~lat_we;
            RAM_ADDR = lat_addr;
            RAM_DIN  = lat_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            lat_we    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 32'h0;
            wait_cnt  <= 8'h00;
        end else if (accept) begin
            lat_we    <= HOST_WE;
            lat_addr  <= HOST_ADDR;
            lat_wdata <= HOST_WDATA;
            wait_cnt  <= 8'h00;
        end else if (blocked) begin
            wait_cnt  <= wait_cnt + 8'd1;
        end
    end

    // RAM_DOUT reflects the WAIT-cycle access during CAPT, regardless of what the engine does then.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
            if (timeout) begin
                rdata_q <= 32'h0;
            end else if (state == CAPT && !lat_we) begin
                rdata_q <= RAM_DOUT;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            stall_q <= 16'h0000;
        end else if (CNT_CLR) begin
            stall_q <= 16'h0000;
        end else if (blocked && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign HOST_ACK   = (state == ACK);
    assign HOST_ERR   = (state == ACK) && err_q;
    assign HOST_RDATA = rdata_q;
    assign STALL_CNT  = stall_q;
    assign ENG_RDATA  = RAM_DOUT;

endmodule
